simple_resp: RTL and testbench
==============================

# simple_resp

Responder for the `simple` interface: the `dir2` end that reads `simple1` and drives `simple2`. It detects each new word the `dir1` side places on `simple1` and buffers it in a small FIFO. It pops words at a paced rate and drives a running modular sum of all popped words back on `simple2`. It sits beside the `dir1` writer, for example `submodule`, as the instance that closes the loop on a `simple` interface instance.

## Interface
- `WIDTH`, default 32: data width. Must equal the connected interface's `WIDTH`.
- `DEPTH`, default 4: FIFO entries. Power of two, 2..16.
- `HOLD`, default 2: minimum cycles between pops, ≥1.
- `clk`, input, 1: clock. Everything is rising-edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `conn`, interface port `simple.dir2`, WIDTH: reads `conn.simple1`; drives `conn.simple2` from a register.
- `level`, output, $clog2(DEPTH)+1: FIFO occupancy, registered.
- `busy`, output, 1: high when the FIFO is non-empty or the state is WAIT.
- `ovf`, output, 1: sticky overflow flag. Present only with `SIMPLE_RESP_OVF_EN`.

## Operation
- Registers and reset values (all synchronous on `rst`):
  - `last1` = 0
  - `acc` = 0
  - `simple2` = 0
  - `level` = 0
  - FIFO pointers = 0
  - state = IDLE
  - `cnt` = 0
  - `ovf` = 0
  - `rst` overrides all activity in the same cycle.
- Change detect: a cycle is a push request when `conn.simple1 != last1`. On every push request, `last1 <= conn.simple1` at the edge, whether or not the push is accepted.
  - Consequence: a repeated identical word is not a new word.
  - Consequence: a word equal to 0 immediately after reset is not detected.
- Push accept: when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle. The word is written at the tail.
- Rejected push: the word is discarded and `ovf <= 1`.
- State machine:
  - IDLE with `level > 0`: pop the head word `w`.
    - `acc <= acc + w`, and `simple2 <= acc + w`, summed mod 2^WIDTH.
    - If HOLD > 1: `cnt <= HOLD-1`, go to WAIT.
    - If HOLD = 1: stay in IDLE.
  - IDLE with `level == 0`: hold all values.
  - WAIT: `cnt <= cnt-1`. Go to IDLE when `cnt == 1`.
- Push and pop in the same cycle: `level` is unchanged.
- Pointers wrap modulo DEPTH. `level` saturates at DEPTH and never exceeds it.
- `simple2` changes only on a pop or on reset.

## Timing
- Push: a new word on `simple1` during cycle t is written at edge t. `level` increments after edge t.
- Latency, empty FIFO and IDLE: pop occurs at edge t+1, so `simple2` shows the updated sum after edge t+1. That is 2 edges after the change.
- Pop spacing: consecutive pops are exactly HOLD cycles apart while the FIFO stays non-empty.
- Push rate: one push per cycle maximum.
- Reset mid-operation: the FIFO contents are lost and `acc` clears.
  - `last1` = 0, so a non-zero `simple1` still present is re-captured in the first cycle after `rst` falls.

## Configuration
- `SIMPLE_RESP_OVF_EN` defined: the `ovf` port and sticky register exist. `ovf` is set by a rejected push and cleared only by `rst`.
- Not defined: no `ovf` port and no register. Rejected pushes are dropped silently. All other behaviour is identical.

## Test plan
- Reset, `simple1` held at 0 for 10 cycles -> `simple2` = 0, `level` = 0, `busy` = 0 throughout.
- `simple1` changes 0 -> 0x000055AA in cycle 5 -> `level` = 1 after edge 5; `simple2` = 0x000055AA after edge 6, `level` = 0.
- HOLD=2, `simple1` = 1, 2, 3 on consecutive cycles -> `simple2` = 1, 3, 6, updated at edges 2 cycles apart; `busy` drops after the last WAIT.
- DEPTH=4, HOLD=8, six distinct words on consecutive cycles w0..w5 -> w0 popped at edge 1; w1..w4 fill the FIFO; w5 is rejected, `ovf` = 1 (macro on); `simple2` = w0, then w0+w1 eight cycles later.
- Wrap: words 0xFFFFFFFF then 0x00000002 -> `simple2` = 0xFFFFFFFF, then 0x00000001.
- `level` = 3 in WAIT, `rst` high one cycle with `simple1` = 0x1234 -> next cycle `simple2` = 0, `level` = 0, `ovf` = 0. After `rst` falls, 0x1234 is re-captured and `simple2` = 0x00001234 two edges later.

Source files
------------

// File: rtl/simple_resp_if.sv
// simple: two-ended word interface; dir1 (master) drives simple1, dir2 (slave) drives simple2.
interface simple #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] simple1;
  logic [WIDTH-1:0] simple2;

  modport dir1   (output simple1, input  simple2);
  modport dir2   (input  simple1, output simple2);
  modport master (output simple1, input  simple2);
  modport slave  (input  simple1, output simple2);
endinterface

// File: rtl/simple_resp.sv
// simple_resp: dir2 responder; buffers each new simple1 word and returns a paced running sum on simple2.
// Optional sticky overflow flag and ovf port exist only when SIMPLE_RESP_OVF_EN is defined.
module simple_resp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  simple.dir2                     conn,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
`ifdef SIMPLE_RESP_OVF_EN
  ,
  output logic                    ovf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] last1;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push_req, push_ok, pop;
  logic [WIDTH-1:0] sum;

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign pop      = (state_q == IDLE) && (level != '0);
  assign push_req = (conn.simple1 != last1);
  assign push_ok  = push_req && ((level != LW'(DEPTH)) || pop);
  assign sum      = wrap_add(acc, mem[rptr]);
  assign busy     = (level != '0) || (state_q == WAIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pop && (HOLD > 1)) begin
          cnt_d   = CW'(HOLD - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last1        <= '0;
      acc          <= '0;
      conn.simple2 <= '0;
      level        <= '0;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push_req) last1 <= conn.simple1;
      if (push_ok)  wptr  <= wptr + 1'b1;
      if (pop) begin
        rptr         <= rptr + 1'b1;
        acc          <= sum;
        conn.simple2 <= sum;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wptr] <= conn.simple1;
  end

`ifdef SIMPLE_RESP_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)                       ovf <= 1'b0;
    else if (push_req && !push_ok) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_simple_resp.sv
// Directed bench for simple_resp: vector table on a HOLD=2 instance, hand sequence on a HOLD=8 instance.
module tb_simple_resp;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] level_a, level_b;
  logic       busy_a, busy_b;
`ifdef SIMPLE_RESP_OVF_EN
  logic       ovf_a, ovf_b;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simple #(.WIDTH(32)) ifa ();
  simple #(.WIDTH(32)) ifb ();

  simple_resp #(.WIDTH(32), .DEPTH(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst_a), .conn(ifa.dir2), .level(level_a), .busy(busy_a)
`ifdef SIMPLE_RESP_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  simple_resp #(.WIDTH(32), .DEPTH(4), .HOLD(8)) dut8 (
    .clk(clk), .rst(rst_b), .conn(ifb.dir2), .level(level_b), .busy(busy_b)
`ifdef SIMPLE_RESP_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] s1;
    logic [31:0] exp_s2;
    logic [2:0]  exp_level;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] s1, input logic [31:0] s2,
                     input logic [2:0] lv, input logic b);
    vec_t v;
    v.rst = r; v.s1 = s1; v.exp_s2 = s2; v.exp_level = lv; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w [6];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.simple1 = '0; ifb.simple1 = '0;

    // reset, then idle with simple1 at 0
    add(1, 32'h0, 32'h0, 3'd0, 0);
    for (int i = 0; i < 10; i++) add(0, 32'h0, 32'h0, 3'd0, 0);
    // single word: push, pop one edge later, WAIT, idle
    add(0, 32'h55AA, 32'h0,    3'd1, 1);
    add(0, 32'h55AA, 32'h55AA, 3'd0, 1);
    add(0, 32'h55AA, 32'h55AA, 3'd0, 0);
    add(1, 32'h55AA, 32'h0,    3'd0, 0);
    add(0, 32'h0,    32'h0,    3'd0, 0);
    // 1,2,3 back to back -> sums 1,3,6 two edges apart
    add(0, 32'd1, 32'd0, 3'd1, 1);
    add(0, 32'd2, 32'd1, 3'd1, 1);
    add(0, 32'd3, 32'd1, 3'd2, 1);
    add(0, 32'd3, 32'd3, 3'd1, 1);
    add(0, 32'd3, 32'd3, 3'd1, 1);
    add(0, 32'd3, 32'd6, 3'd0, 1);
    add(0, 32'd3, 32'd6, 3'd0, 0);
    // modular wrap
    add(1, 32'd3,          32'h0,          3'd0, 0);
    add(0, 32'hFFFFFFFF,   32'h0,          3'd1, 1);
    add(0, 32'h2,          32'hFFFFFFFF,   3'd1, 1);
    add(0, 32'h2,          32'hFFFFFFFF,   3'd1, 1);
    add(0, 32'h2,          32'h1,          3'd0, 1);
    add(0, 32'h2,          32'h1,          3'd0, 0);
    // build level 3 in WAIT, then reset with 0x1234 present
    add(1, 32'h0,  32'h0,  3'd0, 0);
    add(0, 32'd10, 32'd0,  3'd1, 1);
    add(0, 32'd11, 32'd10, 3'd1, 1);
    add(0, 32'd12, 32'd10, 3'd2, 1);
    add(0, 32'd13, 32'd21, 3'd2, 1);
    add(0, 32'd14, 32'd21, 3'd3, 1);
    add(0, 32'd15, 32'd33, 3'd3, 1);
    add(1, 32'h1234, 32'h0,    3'd0, 0);
    add(0, 32'h1234, 32'h0,    3'd1, 1);
    add(0, 32'h1234, 32'h1234, 3'd0, 1);
    add(0, 32'h1234, 32'h1234, 3'd0, 0);

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst;
      ifa.simple1 = vecs[i].s1;
      step();
      chk($sformatf("v%0d simple2", i), ifa.simple2, vecs[i].exp_s2);
      chk($sformatf("v%0d level", i), {29'd0, level_a}, {29'd0, vecs[i].exp_level});
      chk($sformatf("v%0d busy", i), {31'd0, busy_a}, {31'd0, vecs[i].exp_busy});
`ifdef SIMPLE_RESP_OVF_EN
      chk($sformatf("v%0d ovf", i), {31'd0, ovf_a}, 32'd0);
`endif
    end

    // HOLD=8 overflow sequence, w0..w5 on consecutive cycles
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    w[3] = 32'h44; w[4] = 32'h55; w[5] = 32'h66;
    step();
    chk("h8 reset simple2", ifb.simple2, 32'h0);
    chk("h8 reset level", {29'd0, level_b}, 32'd0);
    for (int k = 0; k < 42; k++) begin
      rst_b = 1'b0;
      ifb.simple1 = (k < 6) ? w[k] : w[5];
      step();
      case (k)
        0: chk("h8 e0 level", {29'd0, level_b}, 32'd1);
        1: chk("h8 e1 simple2", ifb.simple2, w[0]);
        4: begin
          chk("h8 e4 level", {29'd0, level_b}, 32'd4);
`ifdef SIMPLE_RESP_OVF_EN
          chk("h8 e4 ovf", {31'd0, ovf_b}, 32'd0);
`endif
        end
        5: begin
          chk("h8 e5 level", {29'd0, level_b}, 32'd4);
`ifdef SIMPLE_RESP_OVF_EN
          chk("h8 e5 ovf", {31'd0, ovf_b}, 32'd1);
`endif
        end
        8: chk("h8 e8 simple2", ifb.simple2, w[0]);
        9: begin
          chk("h8 e9 simple2", ifb.simple2, w[0] + w[1]);
          chk("h8 e9 level", {29'd0, level_b}, 32'd3);
        end
        33: begin
          chk("h8 e33 simple2", ifb.simple2, 32'hFF);
          chk("h8 e33 level", {29'd0, level_b}, 32'd0);
        end
        39: chk("h8 e39 busy", {31'd0, busy_b}, 32'd1);
        40: begin
          chk("h8 e40 busy", {31'd0, busy_b}, 32'd0);
`ifdef SIMPLE_RESP_OVF_EN
          chk("h8 e40 ovf sticky", {31'd0, ovf_b}, 32'd1);
`endif
        end
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
